mux2x1_rr: RTL and testbench

MUX2X1_RR -- requirements
Module: mux2x1_rr

---
 rtl/mux2x1_rr_pkg.sv | 10 +
 rtl/mux2x1_rr_fifo_lane.sv | 72 +++++++
 rtl/mux2x1_rr.sv | 105 ++++++++++
 tb/tb_mux2x1_rr.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux2x1_rr_pkg.sv
// Shared constants for the two-lane round-robin merge block.
package mux2x1_rr_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/mux2x1_rr_fifo_lane.sv
// Per-lane FIFO. A push is judged against the count before any same-cycle pop,
// so a full lane refuses a write even while it is being drained.
module fifo_lane
  import mux2x1_rr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rptr_q];
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  // Next-state: pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 1'b1;
    end
    if (rd_en) rptr_d = rptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; stale entries are unreachable once count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mux2x1_rr.sv
// Two-lane merge: each lane is buffered, a round-robin arbiter picks a lane
// whenever the registered output stage is free, and drops are flagged sticky.
module mux2x1_rr
  import mux2x1_rr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Entrada0,
  input  logic             validEntrada0,
  input  logic [WIDTH-1:0] Entrada1,
  input  logic             validEntrada1,
  input  logic             readyOut,
  output logic [WIDTH-1:0] Salida,
  output logic             validSalida,
  output logic             lleno0,
  output logic             lleno1,
  output logic             overflow0,
  output logic             overflow1
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] head0, head1;
  logic             empty0, empty1;
  logic [CW-1:0]    cnt0, cnt1;
  logic             pop0, pop1;
  logic             free, ne0, ne1, gnt_vld, gnt;

  logic [WIDTH-1:0] salida_q, salida_d;
  logic             valid_q, valid_d;
  logic             last_grant_q, last_grant_d;
  logic             ovf0_q, ovf0_d, ovf1_q, ovf1_d;

  fifo_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk(clk), .reset(reset), .push(validEntrada0), .pop(pop0), .din(Entrada0),
    .dout(head0), .full(lleno0), .empty(empty0), .count(cnt0)
  );

  fifo_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk(clk), .reset(reset), .push(validEntrada1), .pop(pop1), .din(Entrada1),
    .dout(head1), .full(lleno1), .empty(empty1), .count(cnt1)
  );

  // Arbitration and output-stage next state; contention goes to the lane not served last.
  always_comb begin
    free    = ~valid_q | readyOut;
    ne0     = (cnt0 != '0);
    ne1     = (cnt1 != '0);
    gnt_vld = 1'b0;
    gnt     = LANE0;
    if (free) begin
      if (ne0 && ne1) begin
        gnt_vld = 1'b1;
        gnt     = (last_grant_q == LANE0) ? LANE1 : LANE0;
      end else if (ne0) begin
        gnt_vld = 1'b1;
        gnt     = LANE0;
      end else if (ne1) begin
        gnt_vld = 1'b1;
        gnt     = LANE1;
      end
    end
    pop0 = gnt_vld & (gnt == LANE0) & ~empty0;
    pop1 = gnt_vld & (gnt == LANE1) & ~empty1;

    salida_d     = salida_q;
    valid_d      = valid_q;
    last_grant_d = last_grant_q;
    if (free) begin
      valid_d = gnt_vld;
      if (gnt_vld) begin
        salida_d     = (gnt == LANE1) ? head1 : head0;
        last_grant_d = gnt;
      end
    end
    ovf0_d = ovf0_q | (validEntrada0 & lleno0);
    ovf1_d = ovf1_q | (validEntrada1 & lleno1);
  end

  // Output register and sticky flags; reset also discards any word held for readyOut.
  always_ff @(posedge clk) begin
    if (!reset) begin
      salida_q     <= '0;
      valid_q      <= 1'b0;
      last_grant_q <= LANE1;
      ovf0_q       <= 1'b0;
      ovf1_q       <= 1'b0;
    end else begin
      salida_q     <= salida_d;
      valid_q      <= valid_d;
      last_grant_q <= last_grant_d;
      ovf0_q       <= ovf0_d;
      ovf1_q       <= ovf1_d;
    end
  end

  assign Salida      = salida_q;
  assign validSalida = valid_q;
  assign overflow0   = ovf0_q;
  assign overflow1   = ovf1_q;

endmodule

// File: tb/tb_mux2x1_rr.sv
// Directed bench for mux2x1_rr: stimulus pushes expected words into a queue,
// an independent negedge monitor pops and compares on every accepted output.
module tb_mux2x1_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] Entrada0 = '0, Entrada1 = '0;
  logic       validEntrada0 = 1'b0, validEntrada1 = 1'b0;
  logic       readyOut = 1'b0;
  logic [7:0] Salida;
  logic       validSalida, lleno0, lleno1, overflow0, overflow1;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  mux2x1_rr #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .Entrada0(Entrada0), .validEntrada0(validEntrada0),
    .Entrada1(Entrada1), .validEntrada1(validEntrada1),
    .readyOut(readyOut), .Salida(Salida), .validSalida(validSalida),
    .lleno0(lleno0), .lleno1(lleno1), .overflow0(overflow0), .overflow1(overflow1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every word accepted downstream must be the next expected one.
  always @(negedge clk) begin
    if (reset && validSalida && readyOut) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %0h expected none", Salida);
      end else begin
        chk("out_order", Salida, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    validEntrada0 = v0; Entrada0 = d0;
    validEntrada1 = v1; Entrada1 = d1;
  endtask

  task automatic drain();
    drv(1'b0, 8'h00, 1'b0, 8'h00);
    readyOut = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !validSalida) break;
      step();
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", validSalida, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    step(); step();
    chk("rst_salida", Salida, 8'h00);
    chk("rst_valid", validSalida, 1'b0);
    chk("rst_lleno0", lleno0, 1'b0);
    chk("rst_lleno1", lleno1, 1'b0);
    chk("rst_ovf0", overflow0, 1'b0);
    chk("rst_ovf1", overflow1, 1'b0);
    reset = 1'b1;

    // Single lane with latency check
    readyOut = 1'b1;
    drv(1'b1, 8'h11, 1'b0, 8'h00); exp_q.push_back(8'h11); step();
    chk("lat_before", validSalida, 1'b0);
    drv(1'b1, 8'h22, 1'b0, 8'h00); exp_q.push_back(8'h22); step();
    chk("lat_valid", validSalida, 1'b1);
    chk("lat_data", Salida, 8'h11);
    drv(1'b1, 8'h33, 1'b0, 8'h00); exp_q.push_back(8'h33); step();
    drain();

    // Contention from reset: lane 0 first, then alternate
    do_reset();
    readyOut = 1'b1;
    exp_q.push_back(8'h40); exp_q.push_back(8'h50);
    exp_q.push_back(8'h41); exp_q.push_back(8'h51);
    drv(1'b1, 8'h40, 1'b1, 8'h50); step();
    drv(1'b1, 8'h41, 1'b1, 8'h51); step();
    drain();

    // Backpressure, fill, drop of 0x06
    readyOut = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drv(1'b1, 8'(i), 1'b0, 8'h00);
      if (i <= 5) exp_q.push_back(8'(i));
      step();
      if (i == 5) begin
        chk("bp_lleno0", lleno0, 1'b1);
        chk("bp_ovf0_pre", overflow0, 1'b0);
      end
    end
    chk("bp_ovf0", overflow0, 1'b1);
    chk("bp_hold_data", Salida, 8'h01);
    chk("bp_hold_valid", validSalida, 1'b1);
    drain();
    chk("bp_ovf0_sticky", overflow0, 1'b1);
    chk("bp_lleno0_after", lleno0, 1'b0);

    // Pointer wrap through lane 1
    do_reset();
    readyOut = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, 8'h00, 1'b1, 8'hA0 + 8'(i));
      exp_q.push_back(8'hA0 + 8'(i));
      step();
      chk("wrap_lleno1", lleno1, 1'b0);
    end
    drain();
    chk("wrap_ovf1", overflow1, 1'b0);

    // Reset mid-stream with both lanes holding two words and one in Salida
    readyOut = 1'b0;
    drv(1'b1, 8'h60, 1'b1, 8'h70); step();
    drv(1'b1, 8'h61, 1'b1, 8'h71); step();
    drv(1'b1, 8'h62, 1'b0, 8'h00); step();
    chk("mid_pre_valid", validSalida, 1'b1);
    reset = 1'b0;
    readyOut = 1'b1;
    drv(1'b1, 8'hEE, 1'b1, 8'hEE);
    step();
    chk("mid_valid", validSalida, 1'b0);
    chk("mid_salida", Salida, 8'h00);
    chk("mid_lleno0", lleno0, 1'b0);
    chk("mid_lleno1", lleno1, 1'b0);
    reset = 1'b1;
    exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
    drv(1'b1, 8'hC0, 1'b1, 8'hC1); step();
    drain();

    // Full lane plus same-cycle pop: the push is still dropped
    readyOut = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 8'hD0 + 8'(i), 1'b0, 8'h00);
      exp_q.push_back(8'hD0 + 8'(i));
      step();
    end
    chk("fp_lleno0", lleno0, 1'b1);
    chk("fp_ovf0_pre", overflow0, 1'b0);
    readyOut = 1'b1;
    drv(1'b1, 8'h7F, 1'b0, 8'h00); step();
    chk("fp_ovf0", overflow0, 1'b1);
    chk("fp_lleno0_after", lleno0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
